// File: rtl/clk_div_glitchfree.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_glitchfree
// Brief   : Runtime-ratio integer clock divider; ratio/enable changes land on
//           output-period boundaries only, so o_div_clk never produces a runt.
// Revision: 1.0  initial release
// ============================================================================
module clk_div_glitchfree #(
    parameter int DIV_W = 8
) (
    input  logic             i_ref_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [DIV_W-1:0] i_div_ratio,
    output logic             o_div_clk,
    output logic             o_tick,
    output logic             o_active
);

    localparam logic [0:0]       ST_IDLE = 1'b0;
    localparam logic [0:0]       ST_RUN  = 1'b1;
    localparam logic [DIV_W-1:0] C_ONE   = {{(DIV_W-1){1'b0}}, 1'b1};

    logic [0:0]       r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_ratio;
    logic             r_div_clk;
    logic             r_tick;
    logic             r_active;

    logic [0:0]       w_state_nxt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] w_ratio_nxt;
    logic             w_div_nxt;
    logic             w_tick_nxt;
    logic             w_active_nxt;

    logic             w_valid;
    logic [DIV_W-1:0] w_low;
    logic             w_last;
    logic [DIV_W-1:0] w_cnt_wrap;

    // Ratio >= 2 is equivalent to any bit above the LSB being set.
    assign w_valid    = i_clk_en && (i_div_ratio[DIV_W-1:1] != '0);
    assign w_low      = r_ratio >> 1;
    assign w_last     = (r_cnt == (r_ratio - C_ONE));
    assign w_cnt_wrap = w_last ? '0 : (r_cnt + C_ONE);

    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_ratio   <= '0;
            r_div_clk <= 1'b0;
            r_tick    <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_ratio   <= w_ratio_nxt;
            r_div_clk <= w_div_nxt;
            r_tick    <= w_tick_nxt;
            r_active  <= w_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_ratio_nxt  = r_ratio;
        w_div_nxt    = 1'b0;
        w_tick_nxt   = 1'b0;
        w_active_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_valid) begin
                    w_ratio_nxt  = i_div_ratio;
                    w_state_nxt  = ST_RUN;
                    w_active_nxt = 1'b1;
                end
            end
            ST_RUN: begin
                w_cnt_nxt    = w_cnt_wrap;
                w_active_nxt = 1'b1;
                w_div_nxt    = (w_cnt_wrap >= w_low);
                w_tick_nxt   = (w_cnt_wrap == w_low);
                // At the boundary the wrapped count is 0, which is always in the
                // low phase for any new ratio, so a fresh ratio needs no special case.
                if (w_last) begin
                    if (w_valid) begin
                        w_ratio_nxt = i_div_ratio;
                    end else begin
                        w_state_nxt  = ST_IDLE;
                        w_active_nxt = 1'b0;
                        w_div_nxt    = 1'b0;
                        w_tick_nxt   = 1'b0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_div_clk = r_div_clk;
    assign o_tick    = r_tick;
    assign o_active  = r_active;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_glitchfree.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_div_glitchfree
// Brief   : Directed self-checking bench for clk_div_glitchfree.
// Revision: 1.0  initial release
// ============================================================================
module tb_clk_div_glitchfree;

    logic       clk;
    logic       r_rst;
    logic       r_en;
    logic [7:0] r_ratio;
    logic       w_div_clk;
    logic       w_tick;
    logic       w_active;

    int n_cmp;
    int n_err;
    int g_cnt;

    clk_div_glitchfree #(.DIV_W(8)) u_dut (
        .i_ref_clk  (clk),
        .i_rst      (r_rst),
        .i_clk_en   (r_en),
        .i_div_ratio(r_ratio),
        .o_div_clk  (w_div_clk),
        .o_tick     (w_tick),
        .o_active   (w_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b (t=%0t cnt=%0d)", tag, obs, exp, $time, g_cnt);
        end
    endtask

    task automatic chk3(input string tag, input logic d, input logic t, input logic a);
        chk({tag, ".div_clk"}, w_div_clk, d);
        chk({tag, ".tick"},    w_tick,    t);
        chk({tag, ".active"},  w_active,  a);
    endtask

    // Expected waveform of a running divider: low for cnt < N/2, high otherwise,
    // tick on the first high cycle.
    task automatic run(input string tag, input int n, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            g_cnt = (g_cnt == n - 1) ? 0 : g_cnt + 1;
            chk3(tag, (g_cnt >= n / 2), (g_cnt == n / 2), 1'b1);
        end
    endtask

    task automatic idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            chk3(tag, 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        g_cnt   = 0;
        r_rst   = 1'b1;
        r_en    = 1'b0;
        r_ratio = 8'd0;

        // Reset state
        step();
        chk3("reset", 1'b0, 1'b0, 1'b0);
        step();
        chk3("reset2", 1'b0, 1'b0, 1'b0);

        // N=4: start edge, then two full periods
        r_rst   = 1'b0;
        r_en    = 1'b1;
        r_ratio = 8'd4;
        step();
        g_cnt = 0;
        chk3("n4_start", 1'b0, 1'b0, 1'b1);
        run("n4", 4, 8);

        // Switch to N=5 exactly at a boundary
        run("n4_pre5", 4, 3);
        r_ratio = 8'd5;
        run("n4_bnd5", 4, 1);
        run("n5", 5, 10);

        // Switch to N=2
        run("n5_pre2", 5, 4);
        r_ratio = 8'd2;
        run("n5_bnd2", 5, 1);
        run("n2", 2, 6);

        // Back to N=4, then request N=6 mid-period: must wait for the boundary
        run("n2_pre4", 2, 1);
        r_ratio = 8'd4;
        run("n2_bnd4", 2, 1);
        run("n4_mid", 4, 1);
        r_ratio = 8'd6;
        run("n4_drain", 4, 2);
        run("n4_bnd6", 4, 1);
        run("n6", 6, 12);

        // Drop enable in the high phase: high phase completes, then idle
        run("n6_high", 6, 4);
        r_en = 1'b0;
        run("n6_drain", 6, 1);
        step();
        chk3("n6_stop", 1'b0, 1'b0, 1'b0);
        idle("off", 5);

        // Invalid ratios never start the divider
        r_en    = 1'b1;
        r_ratio = 8'd0;
        idle("ratio0", 10);
        r_ratio = 8'd1;
        idle("ratio1", 10);

        // N=3 starts on the next edge
        r_ratio = 8'd3;
        step();
        g_cnt = 0;
        chk3("n3_start", 1'b0, 1'b0, 1'b1);
        run("n3", 3, 3);

        // N=255: full period, 127 low / 128 high
        run("n3_pre255", 3, 2);
        r_ratio = 8'd255;
        run("n3_bnd255", 3, 1);
        run("n255", 255, 255);

        // Reset mid-high phase, then restart on the following edge
        run("n255_high", 255, 130);
        r_rst = 1'b1;
        step();
        chk3("rst_mid", 1'b0, 1'b0, 1'b0);
        r_rst = 1'b0;
        step();
        g_cnt = 0;
        chk3("restart", 1'b0, 1'b0, 1'b1);
        run("restart_run", 255, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
